// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC pipeline: opcode constants, vectors,
// fetch FSM encoding and the IF/ID register layout.
package risc_pkg;

  localparam logic [7:0] NOP_INSTR      = 8'h00;
  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] INTR_VEC_ADDR  = 8'h01;

  // Major opcodes live in instr[7:4]; only TWO_BYTE_OPC carries an immediate byte.
  localparam logic [3:0] OPC_NOP      = 4'h0;
  localparam logic [3:0] OPC_ALU      = 4'h4;
  localparam logic [3:0] OPC_BRANCH   = 4'h8;
  localparam logic [3:0] TWO_BYTE_OPC = 4'hC;
  localparam logic [3:0] OPC_RET      = 4'hE;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_IMM   = 2'd2,
    S_VEC   = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port plus the IF/ID outputs seen by decode.
interface fetch_stage_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] instr_id;
  logic [7:0] immediate;
  logic [7:0] pc_id;
  logic       valid_id;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output instr_id,
    output immediate,
    output pc_id,
    output valid_id
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  instr_id,
    input  immediate,
    input  pc_id,
    input  valid_id
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load; reset forces a bubble.
module if_id_reg
  import risc_pkg::*;
#(
  parameter logic [7:0] NOP_INSTR = risc_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold_i,
  input  logic   bubble_i,
  input  if_id_t data_i,
  output if_id_t data_o
);

  if_id_t ifid_q, ifid_d, bubble;

  assign bubble = '{instr: NOP_INSTR, imm: 8'h00, pc: 8'h00, valid: 1'b0};

  always_comb begin
    ifid_d = ifid_q;
    if (bubble_i) begin
      ifid_d = bubble;
    end else if (!hold_i) begin
      ifid_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= bubble;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign data_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, reset/interrupt vectoring, two-byte assembly and the
// redirect/stall/flush arbitration feeding the IF/ID register.
module fetch_stage
  import risc_pkg::*;
#(
  parameter logic [7:0] RESET_VEC_ADDR = risc_pkg::RESET_VEC_ADDR,
  parameter logic [7:0] INTR_VEC_ADDR  = risc_pkg::INTR_VEC_ADDR,
  parameter logic [7:0] NOP_INSTR      = risc_pkg::NOP_INSTR,
  parameter logic [3:0] TWO_BYTE_OPC   = risc_pkg::TWO_BYTE_OPC
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        bus,
  input  logic                 stall_F,
  input  logic                 stall_D,
  input  logic                 flush_F,
  input  logic                 branch_taken_ex,
  input  logic [7:0]           branch_target,
  input  logic                 pc_load_mem,
  input  logic [7:0]           pc_load_val,
  input  logic                 intr_vec,
  output logic                 intr_pending
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   hold_op_q, hold_op_d;
  logic         intr_pending_q, intr_pending_d;
  logic         hold, ifid_hold, ifid_bubble;
  logic [7:0]   rdata, pc_inc;
  if_id_t       ifid_d, ifid_q;

  assign hold   = stall_F | stall_D;
  assign rdata  = bus.imem_rdata;
  assign pc_inc = pc_q + 8'd1;

  always_comb begin
    unique case (state_q)
      S_RST:   bus.imem_addr = RESET_VEC_ADDR;
      S_VEC:   bus.imem_addr = INTR_VEC_ADDR;
      default: bus.imem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_op_d      = hold_op_q;
    intr_pending_d = intr_pending_q | intr_vec;
    ifid_d         = '{instr: rdata, imm: 8'h00, pc: pc_inc, valid: 1'b1};
    ifid_hold      = 1'b0;
    ifid_bubble    = 1'b0;

    if (state_q == S_RST) begin
      pc_d           = rdata;
      state_d        = S_FETCH;
      intr_pending_d = intr_pending_q;
      ifid_bubble    = 1'b1;
    end else if (pc_load_mem || branch_taken_ex) begin
      // A redirect out of S_VEC leaves intr_pending set so vectoring retries.
      pc_d        = pc_load_mem ? pc_load_val : branch_target;
      state_d     = S_FETCH;
      hold_op_d   = 8'h00;
      ifid_bubble = 1'b1;
    end else if (state_q == S_VEC) begin
      pc_d           = rdata;
      state_d        = S_FETCH;
      intr_pending_d = intr_vec;
      ifid_bubble    = 1'b1;
    end else if (state_q == S_FETCH && intr_pending_q) begin
      state_d     = S_VEC;
      ifid_hold   = stall_D & ~flush_F;
      ifid_bubble = ~ifid_hold;
    end else if (hold) begin
      ifid_hold   = stall_D & ~flush_F;
      ifid_bubble = ~ifid_hold;
    end else if (flush_F) begin
      ifid_bubble = 1'b1;
    end else if (state_q == S_IMM) begin
      ifid_d  = '{instr: hold_op_q, imm: rdata, pc: pc_inc, valid: 1'b1};
      pc_d    = pc_inc;
      state_d = S_FETCH;
    end else if (rdata[7:4] == TWO_BYTE_OPC) begin
      hold_op_d   = rdata;
      pc_d        = pc_inc;
      state_d     = S_IMM;
      ifid_bubble = 1'b1;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_RST;
      pc_q           <= 8'h00;
      hold_op_q      <= 8'h00;
      intr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_op_q      <= hold_op_d;
      intr_pending_q <= intr_pending_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (ifid_hold),
    .bubble_i (ifid_bubble),
    .data_i   (ifid_d),
    .data_o   (ifid_q)
  );

  assign bus.instr_id  = ifid_q.instr;
  assign bus.immediate = ifid_q.imm;
  assign bus.pc_id     = ifid_q.pc;
  assign bus.valid_id  = ifid_q.valid;
  assign intr_pending  = intr_pending_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID entries are queued as stimulus
// is applied and popped whenever a fresh valid entry appears.
module tb_fetch_stage;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_F, stall_D, flush_F;
  logic       branch_taken_ex, pc_load_mem, intr_vec;
  logic [7:0] branch_target, pc_load_val;
  logic       intr_pending;
  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_stage_if bif ();
  assign bif.imem_rdata = mem[bif.imem_addr];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bif),
    .stall_F         (stall_F),
    .stall_D         (stall_D),
    .flush_F         (flush_F),
    .branch_taken_ex (branch_taken_ex),
    .branch_target   (branch_target),
    .pc_load_mem     (pc_load_mem),
    .pc_load_val     (pc_load_val),
    .intr_vec        (intr_vec),
    .intr_pending    (intr_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] i, input logic [7:0] m, input logic [7:0] p);
    sbq.push_back('{instr: i, imm: m, pc: p});
  endtask

  // One clock; a fresh valid IF/ID entry is one not held by stall_D at that edge.
  task automatic tick();
    logic sd;
    exp_t e;
    sd = stall_D;
    @(posedge clk);
    #1;
    if (bif.valid_id && !sd) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_unexpected: observed %0h/%0h/%0h expected none",
               bif.instr_id, bif.immediate, bif.pc_id);
      end else begin
        e = sbq.pop_front();
        check("sb_ifid", {8'h00, bif.instr_id, bif.immediate, bif.pc_id}, {8'h00, e});
      end
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h50 | (8'(i) & 8'h0F);
    mem[0] = 8'h10;
    mem[1] = 8'h80;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    stall_F         = 1'b0;
    stall_D         = 1'b0;
    flush_F         = 1'b0;
    branch_taken_ex = 1'b0;
    branch_target   = 8'h00;
    pc_load_mem     = 1'b0;
    pc_load_val     = 8'h00;
    intr_vec        = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bif.valid_id), 32'd0);
    check("rst_instr", 32'(bif.instr_id), 32'(NOP_INSTR));
    check("rst_pc_id", 32'(bif.pc_id), 32'd0);
    check("rst_intr_pending", 32'(intr_pending), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Reset vector, stall and flush.
    init_mem();
    mem[16] = 8'h41;
    mem[17] = 8'h42;
    mem[18] = 8'h43;
    do_reset();
    check("rst_addr", 32'(bif.imem_addr), 32'h00);
    push(8'h41, 8'h00, 8'h11);
    tick();
    tick();
    check("first_valid", 32'(bif.valid_id), 32'd1);
    stall_F = 1'b1;
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(bif.imem_addr), 32'h11);
      check("stall_instr", 32'(bif.instr_id), 32'h41);
    end
    stall_F = 1'b0;
    stall_D = 1'b0;
    push(8'h42, 8'h00, 8'h12);
    tick();
    flush_F = 1'b1;
    tick();
    check("flush_bubble", 32'(bif.valid_id), 32'd0);
    flush_F = 1'b0;
    push(8'h43, 8'h00, 8'h13);
    tick();

    // Two-byte instruction.
    init_mem();
    mem[16] = 8'hC4;
    mem[17] = 8'h5A;
    mem[18] = 8'h41;
    do_reset();
    tick();
    tick();
    check("pair_bubble", 32'(bif.valid_id), 32'd0);
    push(8'hC4, 8'h5A, 8'h12);
    tick();
    push(8'h41, 8'h00, 8'h13);
    tick();

    // Branch while in S_IMM discards the held opcode.
    init_mem();
    mem[16] = 8'hC4;
    mem[17] = 8'h5A;
    mem[48] = 8'h33;
    do_reset();
    tick();
    tick();
    branch_taken_ex = 1'b1;
    branch_target   = 8'h30;
    tick();
    check("br_bubble", 32'(bif.valid_id), 32'd0);
    check("br_addr", 32'(bif.imem_addr), 32'h30);
    branch_taken_ex = 1'b0;
    push(8'h33, 8'h00, 8'h31);
    tick();

    // Interrupt pulse during S_IMM waits for the pair, then vectors.
    init_mem();
    mem[16]  = 8'hC4;
    mem[17]  = 8'h5A;
    mem[128] = 8'h61;
    do_reset();
    tick();
    tick();
    intr_vec = 1'b1;
    push(8'hC4, 8'h5A, 8'h12);
    tick();
    intr_vec = 1'b0;
    check("intr_set", 32'(intr_pending), 32'd1);
    tick();
    check("vec_bubble", 32'(bif.valid_id), 32'd0);
    check("vec_addr", 32'(bif.imem_addr), 32'(INTR_VEC_ADDR));
    check("vec_pending", 32'(intr_pending), 32'd1);
    tick();
    check("intr_clear", 32'(intr_pending), 32'd0);
    push(8'h61, 8'h00, 8'h81);
    tick();

    // Redirect priority and PC wrap.
    init_mem();
    do_reset();
    tick();
    push(8'h50, 8'h00, 8'h11);
    tick();
    pc_load_mem     = 1'b1;
    pc_load_val     = 8'h22;
    branch_taken_ex = 1'b1;
    branch_target   = 8'h30;
    tick();
    check("prio_bubble", 32'(bif.valid_id), 32'd0);
    check("prio_addr", 32'(bif.imem_addr), 32'h22);
    pc_load_mem     = 1'b0;
    branch_taken_ex = 1'b0;
    push(8'h52, 8'h00, 8'h23);
    tick();
    mem[8'hFF]      = 8'h47;
    branch_taken_ex = 1'b1;
    branch_target   = 8'hFF;
    tick();
    branch_taken_ex = 1'b0;
    push(8'h47, 8'h00, 8'h00);
    tick();
    mem[8'hFF]      = 8'hC7;
    branch_taken_ex = 1'b1;
    tick();
    branch_taken_ex = 1'b0;
    tick();
    check("wrap_pair_bubble", 32'(bif.valid_id), 32'd0);
    push(8'hC7, 8'h10, 8'h01);
    tick();

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
